el2_dec_nbload_scbd: RTL and testbench

// Non-blocking-load scoreboard directly upstream of the GPR register file's third write port.

---
 rtl/el2_dec_nbload_scbd_if.sv | 37 +++
 rtl/el2_dec_nbload_scbd.sv | 74 +++++++
 tb/tb_el2_dec_nbload_scbd.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/el2_dec_nbload_scbd_if.sv
// el2_dec_nbload_scbd_if: issue/return/kill/flush and GPR port bundle around the non-blocking-load scoreboard
interface el2_dec_nbload_scbd_if #(parameter int NUM_TAGS = 4, parameter int TAG_W = 2);
   logic                alloc_valid;
   logic [TAG_W-1:0]    alloc_tag;
   logic [4:0]          alloc_rd;
   logic                ret_valid;
   logic [TAG_W-1:0]    ret_tag;
   logic [31:0]         ret_data;
   logic                kill_valid;
   logic [TAG_W-1:0]    kill_tag;
   logic                flush_all;
   logic                wen0;
   logic                wen1;
   logic [4:0]          waddr0;
   logic [4:0]          waddr1;
   logic [4:0]          raddr0;
   logic [4:0]          raddr1;
   logic                wen2;
   logic [4:0]          waddr2;
   logic [31:0]         wd2;
   logic                stall0;
   logic                stall1;
   logic [NUM_TAGS-1:0] busy;
   logic                full;
   logic                err_alloc;
   logic                err_ret;
   modport master (
      output alloc_valid, alloc_tag, alloc_rd, ret_valid, ret_tag, ret_data, kill_valid, kill_tag,
             flush_all, wen0, wen1, waddr0, waddr1, raddr0, raddr1,
      input  wen2, waddr2, wd2, stall0, stall1, busy, full, err_alloc, err_ret
   );
   modport slave (
      input  alloc_valid, alloc_tag, alloc_rd, ret_valid, ret_tag, ret_data, kill_valid, kill_tag,
             flush_all, wen0, wen1, waddr0, waddr1, raddr0, raddr1,
      output wen2, waddr2, wd2, stall0, stall1, busy, full, err_alloc, err_ret
   );
endinterface

// File: rtl/el2_dec_nbload_scbd.sv
// el2_dec_nbload_scbd: tracks destination GPRs of outstanding non-blocking loads and drives GPR write port 2
module el2_dec_nbload_scbd #(parameter int NUM_TAGS = 4, parameter int TAG_W = 2) (
   input logic                  clk,
   input logic                  rst_l,
   el2_dec_nbload_scbd_if.slave bus
);
   logic [NUM_TAGS-1:0] valid_q, stale_q, valid_d, stale_d, freed, install, hit0, hit1;
   logic [4:0]          rd_q [NUM_TAGS];
   logic [4:0]          rd_d [NUM_TAGS];
   logic [4:0]          ret_rd, waddr2_q;
   logic [31:0]         wd2_q;
   logic                wen2_q, err_alloc_q, err_ret_q;
   logic                ret_kill, ret_hit, alloc_ok, wr_d, err_alloc_d, err_ret_d;
   always_comb begin
      for (int i = 0; i < NUM_TAGS; i++) begin
         freed[i] = bus.flush_all | (bus.ret_valid & bus.ret_tag == TAG_W'(i)) |
                    (bus.kill_valid & bus.kill_tag == TAG_W'(i));
         hit0[i] = valid_q[i] & ~stale_q[i] & rd_q[i] == bus.raddr0;
         hit1[i] = valid_q[i] & ~stale_q[i] & rd_q[i] == bus.raddr1;
      end
   end
   // A same-cycle port 0/1 write to the returning rd is younger, so the load result is dropped
   always_comb begin
      ret_rd = rd_q[bus.ret_tag];
      ret_kill = bus.kill_valid & bus.kill_tag == bus.ret_tag;
      ret_hit = bus.ret_valid & valid_q[bus.ret_tag] & ~ret_kill;
      wr_d = ret_hit & ~stale_q[bus.ret_tag] & ~bus.flush_all &
             ~(bus.wen0 & bus.waddr0 == ret_rd) & ~(bus.wen1 & bus.waddr1 == ret_rd);
      err_ret_d = bus.ret_valid & ~valid_q[bus.ret_tag] & ~ret_kill;
      alloc_ok = bus.alloc_valid & |bus.alloc_rd & ~bus.flush_all &
                 (~valid_q[bus.alloc_tag] | freed[bus.alloc_tag]);
      err_alloc_d = bus.alloc_valid & |bus.alloc_rd & ~bus.flush_all &
                    valid_q[bus.alloc_tag] & ~freed[bus.alloc_tag];
      for (int i = 0; i < NUM_TAGS; i++) begin
         install[i] = alloc_ok & bus.alloc_tag == TAG_W'(i);
         valid_d[i] = valid_q[i] & ~freed[i] | install[i];
         stale_d[i] = ~install[i] & valid_d[i] & (stale_q[i] | bus.wen0 & bus.waddr0 == rd_q[i] |
                      bus.wen1 & bus.waddr1 == rd_q[i] | alloc_ok & bus.alloc_rd == rd_q[i]);
         rd_d[i] = install[i] ? bus.alloc_rd : rd_q[i];
      end
   end
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         valid_q <= '0;
         stale_q <= '0;
         rd_q <= '{default: '0};
         wen2_q <= 1'b0;
         waddr2_q <= '0;
         wd2_q <= '0;
         err_alloc_q <= 1'b0;
         err_ret_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
         stale_q <= stale_d;
         rd_q <= rd_d;
         wen2_q <= wr_d;
         if (wr_d) begin
            waddr2_q <= ret_rd;
            wd2_q <= bus.ret_data;
         end
         err_alloc_q <= err_alloc_d;
         err_ret_q <= err_ret_d;
      end
   end
   assign bus.wen2 = wen2_q & ~(bus.wen0 & bus.waddr0 == waddr2_q) & ~(bus.wen1 & bus.waddr1 == waddr2_q);
   assign bus.waddr2 = waddr2_q;
   assign bus.wd2 = wd2_q;
   assign bus.stall0 = |bus.raddr0 & (|hit0 | wen2_q & waddr2_q == bus.raddr0);
   assign bus.stall1 = |bus.raddr1 & (|hit1 | wen2_q & waddr2_q == bus.raddr1);
   assign bus.busy = valid_q;
   assign bus.full = &valid_q;
   assign bus.err_alloc = err_alloc_q;
   assign bus.err_ret = err_ret_q;
endmodule

// File: tb/tb_el2_dec_nbload_scbd.sv
// tb_el2_dec_nbload_scbd: directed vector table, then randomized traffic checked against a per-tag scoreboard model
module tb_el2_dec_nbload_scbd;
   typedef struct {bit rst, av; bit [1:0] at; bit [4:0] ard; bit rv; bit [1:0] rt; bit [31:0] rdat;
                   bit kv; bit [1:0] kt; bit fl, w0; bit [4:0] wa0; bit w1; bit [4:0] wa1, ra0, ra1;} vec_t;
   typedef struct {bit wen2; bit [4:0] wa2; bit [31:0] wd2; bit s0, s1; bit [3:0] busy; bit ea, er;} out_t;
   typedef struct {vec_t v; out_t e;} row_t;
   typedef struct {bit v, s; bit [4:0] rd;} ent_t;

   logic clk = 1'b0;
   logic rst_l = 1'b0;
   always #5 clk = ~clk;

   el2_dec_nbload_scbd_if #(.NUM_TAGS(4), .TAG_W(2)) bus ();
   el2_dec_nbload_scbd #(.NUM_TAGS(4), .TAG_W(2)) dut (.clk(clk), .rst_l(rst_l), .bus(bus));

   ent_t      m [4];
   bit        m_wen, m_ea, m_er;
   bit [4:0]  m_wa;
   bit [31:0] m_wd;
   int        n_chk = 0;
   int        n_fail = 0;
   row_t      tab [$];

   function automatic vec_t mk(int rst, av, at, ard, rv, rt, bit [31:0] rdat, int kv, kt, fl, w0, wa0, ra0, ra1);
      vec_t v;
      v.rst = rst != 0; v.av = av != 0; v.at = 2'(at); v.ard = 5'(ard);
      v.rv = rv != 0; v.rt = 2'(rt); v.rdat = rdat; v.kv = kv != 0; v.kt = 2'(kt);
      v.fl = fl != 0; v.w0 = w0 != 0; v.wa0 = 5'(wa0); v.w1 = 1'b0; v.wa1 = 5'd0;
      v.ra0 = 5'(ra0); v.ra1 = 5'(ra1);
      return v;
   endfunction

   function automatic out_t ex(int wen2, wa2, bit [31:0] wd2, int s0, s1, bit [3:0] busy, int ea, er);
      out_t e;
      e.wen2 = wen2 != 0; e.wa2 = 5'(wa2); e.wd2 = wd2; e.s0 = s0 != 0; e.s1 = s1 != 0;
      e.busy = busy; e.ea = ea != 0; e.er = er != 0;
      return e;
   endfunction

   task automatic add(vec_t v, out_t e);
      row_t r;
      r.v = v;
      r.e = e;
      tab.push_back(r);
   endtask

   function automatic void model_clear();
      foreach (m[t]) m[t] = '{default: '0};
      m_wen = 1'b0; m_wa = 5'd0; m_wd = 32'd0; m_ea = 1'b0; m_er = 1'b0;
   endfunction

   // Events of one cycle in order: younger writes mark stale, return decides writeback, frees, then allocation
   function automatic void model_update(vec_t v);
      ent_t n [4];
      bit killed;
      n = m;
      killed = v.kv && v.kt == v.rt;
      m_wen = 1'b0; m_ea = 1'b0; m_er = 1'b0;
      foreach (n[t])
         if (n[t].v && ((v.w0 && v.wa0 == n[t].rd) || (v.w1 && v.wa1 == n[t].rd))) n[t].s = 1'b1;
      if (v.rv && !killed) begin
         if (!m[v.rt].v) m_er = 1'b1;
         else if (!n[v.rt].s && !v.fl) begin
            m_wen = 1'b1; m_wa = n[v.rt].rd; m_wd = v.rdat;
         end
      end
      if (v.rv) n[v.rt].v = 1'b0;
      if (v.kv) n[v.kt].v = 1'b0;
      if (v.fl) foreach (n[t]) n[t].v = 1'b0;
      else if (v.av && v.ard != 0) begin
         if (n[v.at].v) m_ea = 1'b1;
         else begin
            foreach (n[t]) if (n[t].v && n[t].rd == v.ard) n[t].s = 1'b1;
            n[v.at].v = 1'b1; n[v.at].s = 1'b0; n[v.at].rd = v.ard;
         end
      end
      m = n;
   endfunction

   function automatic bit exp_stall(bit [4:0] ra);
      if (ra == 0) return 1'b0;
      if (m_wen && m_wa == ra) return 1'b1;
      foreach (m[t]) if (m[t].v && !m[t].s && m[t].rd == ra) return 1'b1;
      return 1'b0;
   endfunction

   function automatic out_t model_out(vec_t v);
      out_t e;
      e.wen2 = m_wen && !(v.w0 && v.wa0 == m_wa) && !(v.w1 && v.wa1 == m_wa);
      e.wa2 = m_wa; e.wd2 = m_wd;
      e.s0 = exp_stall(v.ra0); e.s1 = exp_stall(v.ra1);
      foreach (m[t]) e.busy[t] = m[t].v;
      e.ea = m_ea; e.er = m_er;
      return e;
   endfunction

   task automatic drive(vec_t v);
      rst_l = !v.rst;
      bus.alloc_valid = v.av; bus.alloc_tag = v.at; bus.alloc_rd = v.ard;
      bus.ret_valid = v.rv; bus.ret_tag = v.rt; bus.ret_data = v.rdat;
      bus.kill_valid = v.kv; bus.kill_tag = v.kt; bus.flush_all = v.fl;
      bus.wen0 = v.w0; bus.waddr0 = v.wa0; bus.wen1 = v.w1; bus.waddr1 = v.wa1;
      bus.raddr0 = v.ra0; bus.raddr1 = v.ra1;
   endtask

   task automatic check(string name, out_t e);
      bit ok;
      ok = bus.wen2 === e.wen2 && bus.stall0 === e.s0 && bus.stall1 === e.s1 && bus.busy === e.busy &&
           bus.full === &e.busy && bus.err_alloc === e.ea && bus.err_ret === e.er &&
           (!e.wen2 || (bus.waddr2 === e.wa2 && bus.wd2 === e.wd2));
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got wen2=%b waddr2=%0d wd2=%h stall=%b%b busy=%b full=%b err_alloc=%b err_ret=%b; want wen2=%b waddr2=%0d wd2=%h stall=%b%b busy=%b full=%b err_alloc=%b err_ret=%b",
                  name, bus.wen2, bus.waddr2, bus.wd2, bus.stall0, bus.stall1, bus.busy, bus.full, bus.err_alloc, bus.err_ret,
                  e.wen2, e.wa2, e.wd2, e.s0, e.s1, e.busy, &e.busy, e.ea, e.er);
      end
   endtask

   task automatic step(string name, vec_t v, bit use_tab, out_t e);
      @(negedge clk);
      drive(v);
      if (v.rst) model_clear();
      #1;
      if (use_tab) check(name, e);
      else check(name, model_out(v));
      @(posedge clk);
      if (!v.rst) model_update(v);
   endtask

   initial begin
      vec_t idle;
      out_t none;
      idle = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0);
      none = ex(0,0,0,0,0,4'b0000,0,0);
      model_clear();
      drive(mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
      repeat (2) @(posedge clk);
      //      rst av at ard rv rt rdat          kv kt fl w0 wa0 ra0 ra1       wen2 wa2 wd2 s0 s1 busy ea er
      add(mk(0, 1, 1, 5, 0, 0, 0,             0, 0, 0, 0, 0,  0,  0), ex(0, 0, 0,            0, 0, 4'b0000, 0, 0));
      add(idle,                                                        ex(0, 0, 0,            0, 0, 4'b0010, 0, 0));
      add(idle,                                                        ex(0, 0, 0,            0, 0, 4'b0010, 0, 0));
      add(mk(0, 0, 0, 0, 1, 1, 32'hDEADBEEF,  0, 0, 0, 0, 0,  0,  0), ex(0, 0, 0,            0, 0, 4'b0010, 0, 0));
      add(mk(0, 1, 0, 7, 0, 0, 0,             0, 0, 0, 0, 0,  7,  0), ex(1, 5, 32'hDEADBEEF, 0, 0, 4'b0000, 0, 0));
      add(mk(0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0,  7,  0), ex(0, 0, 0,            1, 0, 4'b0001, 0, 0));
      add(mk(0, 0, 0, 0, 1, 0, 32'h11112222,  0, 0, 0, 0, 0,  7,  0), ex(0, 0, 0,            1, 0, 4'b0001, 0, 0));
      add(mk(0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0,  7,  0), ex(1, 7, 32'h11112222, 1, 0, 4'b0000, 0, 0));
      add(mk(0, 1, 2, 9, 0, 0, 0,             0, 0, 0, 0, 0,  7,  0), ex(0, 0, 0,            0, 0, 4'b0000, 0, 0));
      add(mk(0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0,  0,  9), ex(0, 0, 0,            0, 1, 4'b0100, 0, 0));
      add(mk(0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 1, 9,  0,  9), ex(0, 0, 0,            0, 1, 4'b0100, 0, 0));
      add(mk(0, 0, 0, 0, 1, 2, 32'h33,        0, 0, 0, 0, 0,  0,  9), ex(0, 0, 0,            0, 0, 4'b0100, 0, 0));
      add(mk(0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0,  0,  9), none);
      add(mk(0, 1, 0, 1, 0, 0, 0,             0, 0, 0, 0, 0,  0,  0), none);
      add(mk(0, 1, 1, 2, 0, 0, 0,             0, 0, 0, 0, 0,  0,  0), ex(0, 0, 0,            0, 0, 4'b0001, 0, 0));
      add(mk(0, 1, 2, 3, 0, 0, 0,             0, 0, 0, 0, 0,  0,  0), ex(0, 0, 0,            0, 0, 4'b0011, 0, 0));
      add(mk(0, 1, 3, 4, 0, 0, 0,             0, 0, 0, 0, 0,  0,  0), ex(0, 0, 0,            0, 0, 4'b0111, 0, 0));
      add(mk(0, 1, 3, 20, 0, 0, 0,            0, 0, 0, 0, 0,  4,  0), ex(0, 0, 0,            1, 0, 4'b1111, 0, 0));
      add(mk(0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0,  4, 20), ex(0, 0, 0,            1, 0, 4'b1111, 1, 0));
      add(mk(0, 0, 0, 0, 1, 3, 32'h44,        1, 3, 0, 0, 0,  0,  0), ex(0, 0, 0,            0, 0, 4'b1111, 0, 0));
      add(mk(0, 1, 0, 12, 1, 0, 32'h55,       0, 0, 0, 0, 0,  0,  0), ex(0, 0, 0,            0, 0, 4'b0111, 0, 0));
      add(mk(0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 12,  1), ex(1, 1, 32'h55,       1, 1, 4'b0111, 0, 0));
      add(mk(1, 0, 0, 0, 1, 1, 32'h66,        0, 0, 0, 0, 0,  0,  0), none);
      add(mk(0, 0, 0, 0, 1, 1, 32'h77,        0, 0, 0, 0, 0,  0,  0), none);
      add(idle,                                                        ex(0, 0, 0,            0, 0, 4'b0000, 0, 1));
      add(idle,                                                        none);
      add(mk(0, 1, 0, 6, 0, 0, 0,             0, 0, 0, 0, 0,  0,  0), none);
      add(mk(0, 1, 1, 7, 0, 0, 0,             0, 0, 1, 0, 0,  0,  0), ex(0, 0, 0,            0, 0, 4'b0001, 0, 0));
      add(idle,                                                        none);
      foreach (tab[i]) step($sformatf("vec%0d", i), tab[i].v, 1'b1, tab[i].e);
      step("rnd_reset", mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0), 1'b0, none);
      for (int c = 0; c < 3000; c++) begin
         vec_t v;
         v.rst = $urandom_range(99) == 0;
         v.av = $urandom_range(1) == 1;
         v.at = 2'($urandom_range(3));
         v.ard = 5'($urandom_range(7));
         v.rv = $urandom_range(9) < 4;
         v.rt = 2'($urandom_range(3));
         v.rdat = $urandom;
         v.kv = $urandom_range(9) == 0;
         v.kt = 2'($urandom_range(3));
         v.fl = $urandom_range(49) == 0;
         v.w0 = $urandom_range(9) < 3;
         v.wa0 = 5'($urandom_range(7));
         v.w1 = $urandom_range(9) < 3;
         v.wa1 = 5'($urandom_range(7));
         v.ra0 = 5'($urandom_range(7));
         v.ra1 = 5'($urandom_range(7));
         step($sformatf("rnd%0d", c), v, 1'b0, none);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
